// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling 8N1 UART receiver feeding a show-ahead FIFO.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   reset      synchronous active-high reset
//   rx_raw     asynchronous serial input (idle high, LSB first)
//   rd         pop strobe, ignored while the FIFO is empty
//   rx_data    FIFO head byte, defined while valid=1
//   valid      FIFO non-empty
//   count      number of occupied FIFO entries
//   overrun    sticky: a byte arrived while the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//   clr_err    clears overrun and frame_err (a coincident set wins)
module uart_rx_fifo #(
    parameter int unsigned FREQ_HZ = 6000000,
    parameter int unsigned BAUDS   = 9600,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_raw,
    input  logic                   rd,
    output logic [7:0]             rx_data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    output logic                   frame_err,
    input  logic                   clr_err
);
    localparam int unsigned OS_DIV = FREQ_HZ / (BAUDS * 16);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned TW     = $clog2(OS_DIV);
    localparam logic [TW-1:0] TickReload = TW'(OS_DIV - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    // Synchronizer
    logic [1:0] sync_q;
    logic       rx;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx_raw};
    end
    assign rx = sync_q[1];

    // Free-running oversample tick; never realigned to the start edge
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tick;

    assign tick   = (tcnt_q == '0);
    assign tcnt_d = tick ? TickReload : tcnt_q - TW'(1);

    // Receive FSM
    state_e     state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] vote_q, vote_d;   // samples from sc=7 and sc=8
    logic [7:0] data_q, data_d;
    logic       push_q, push_d;
    logic       ferr_set;
    logic       decide, wrap, bit_val;

    assign decide  = (sc_q == 4'd9);
    assign wrap    = (sc_q == 4'd15);
    // Third vote is the live rx sampled on the sc=9 tick itself
    assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx) | (vote_q[0] & rx);

    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        idx_d    = idx_q;
        vote_d   = vote_q;
        data_d   = data_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        if (tick) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == 4'd7 || sc_q == 4'd8) vote_d = {vote_q[0], rx};
            unique case (state_q)
                StIdle: begin
                    if (!rx) begin
                        sc_d    = '0;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    if (decide && bit_val) begin
                        state_d = StIdle;
                    end else if (wrap) begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                end
                StData: begin
                    if (decide) data_d[idx_q] = bit_val;
                    if (wrap) begin
                        if (idx_q == 3'd7) state_d = StStop;
                        else               idx_d   = idx_q + 3'd1;
                    end
                end
                StStop: begin
                    if (decide) begin
                        if (bit_val) begin
                            push_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_set = 1'b1;
                            state_d  = StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rx) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q  <= '0;
            state_q <= StIdle;
            sc_q    <= '0;
            idx_q   <= '0;
            vote_q  <= '0;
            data_q  <= '0;
            push_q  <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            state_q <= state_d;
            sc_q    <= sc_d;
            idx_q   <= idx_d;
            vote_q  <= vote_d;
            data_q  <= data_d;
            push_q  <= push_d;
        end
    end

    // Show-ahead FIFO
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          empty, full, pop, wr_en, ovr_set;
    logic          overrun_q, frame_err_q;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign pop     = rd && !empty;
    // When full, a coincident pop frees the slot the push lands in
    assign wr_en   = push_q && (!full || pop);
    assign ovr_set = push_q && full && !rd;

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (pop && !wr_en) count_d = count_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + AW'(1);
            if (pop)   rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            if (ovr_set)      overrun_q <= 1'b1;
            else if (clr_err) overrun_q <= 1'b0;
            if (ferr_set)     frame_err_q <= 1'b1;
            else if (clr_err) frame_err_q <= 1'b0;
        end
    end

    assign rx_data   = mem_q[rptr_q];
    assign valid     = !empty;
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at 1.6 MHz / 10 kBd
// (10 clocks per oversample tick, 160 clocks per bit).
module tb_uart_rx_fifo;
    localparam int unsigned FreqHz = 1600000;
    localparam int unsigned Bauds  = 10000;
    localparam int unsigned Depth  = 16;
    localparam int          BitCyc = 160;
    localparam int          FastCyc = 155;  // ~3% above nominal baud

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_raw = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       valid;
    logic [4:0] count;
    logic       overrun;
    logic       frame_err;

    int   n_total = 0;
    int   n_bad = 0;
    logic found;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .FREQ_HZ(FreqHz),
        .BAUDS  (Bauds),
        .DEPTH  (Depth)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_raw   (rx_raw),
        .rd       (rd),
        .rx_data  (rx_data),
        .valid    (valid),
        .count    (count),
        .overrun  (overrun),
        .frame_err(frame_err),
        .clr_err  (clr_err)
    );

    // Reference tick phase and synchronized line, used to place an rd on the push cycle
    int   ph;
    logic sh1, sh2;

    always @(posedge clk) begin
        if (reset) begin
            ph  <= 0;
            sh1 <= 1'b1;
            sh2 <= 1'b1;
        end else begin
            ph  <= (ph == 0) ? 9 : ph - 1;
            sh1 <= rx_raw;
            sh2 <= sh1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bc, input logic stop);
        rx_raw = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_raw = b[i];
            repeat (bc) @(negedge clk);
        end
        rx_raw = stop;
        repeat (bc) @(negedge clk);
    endtask

    task automatic pop_byte();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle(4);
        reset = 1'b0;
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        idle(50);

        // Basic receive, back-to-back frames
        send_frame(8'h55, BitCyc, 1'b1);
        send_frame(8'hA3, BitCyc, 1'b1);
        idle(20);
        check("basic_count2", count, 2);
        check("basic_valid", valid, 1);
        check("basic_head55", rx_data, 8'h55);
        pop_byte();
        check("basic_headA3", rx_data, 8'hA3);
        check("basic_count1", count, 1);
        pop_byte();
        check("basic_empty", valid, 0);
        check("basic_count0", count, 0);

        // False start glitch
        rx_raw = 1'b0;
        idle(40);
        rx_raw = 1'b1;
        idle(300);
        check("glitch_count", count, 0);
        check("glitch_ferr", frame_err, 0);
        send_frame(8'h3C, BitCyc, 1'b1);
        idle(20);
        check("glitch_next_count", count, 1);
        check("glitch_next_3C", rx_data, 8'h3C);
        pop_byte();

        // Framing error followed by a held-low break
        send_frame(8'h0F, BitCyc, 1'b0);
        check("ferr_set", frame_err, 1);
        check("ferr_no_push", count, 0);
        pulse_clr();
        check("ferr_clr", frame_err, 0);
        idle(3 * BitCyc);
        check("break_once", frame_err, 0);
        check("break_no_push", count, 0);
        rx_raw = 1'b1;
        idle(BitCyc);
        send_frame(8'h81, BitCyc, 1'b1);
        idle(20);
        check("after_break_count", count, 1);
        check("after_break_81", rx_data, 8'h81);
        check("after_break_ferr", frame_err, 0);
        pop_byte();

        // Overrun: 17 frames, no reads
        for (int i = 0; i < 17; i++) send_frame(8'(i), BitCyc, 1'b1);
        idle(20);
        check("ovr_count", count, 16);
        check("ovr_flag", overrun, 1);
        check("ovr_head00", rx_data, 8'h00);
        check("ovr_ferr", frame_err, 0);
        pulse_clr();
        check("ovr_clr", overrun, 0);

        // Full FIFO with an rd aligned to the push cycle of 0x20
        found = 1'b0;
        fork
            send_frame(8'h20, BitCyc, 1'b1);
            begin
                for (int k = 0; k < 400 && !found; k++) begin
                    @(negedge clk);
                    if (ph == 0 && sh2 == 1'b0) found = 1'b1;
                end
                check("align_found", found, 1);
                if (found) begin
                    repeat (1541) @(negedge clk);
                    check("coinc_pop00", rx_data, 8'h00);
                    pop_byte();
                end
            end
        join
        idle(20);
        check("coinc_count", count, 16);
        check("coinc_overrun", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            check("drain_order", rx_data, (i < 15) ? i + 1 : 32'h20);
            pop_byte();
        end
        check("drain_empty", valid, 0);
        check("drain_count", count, 0);

        // Reset mid-frame, with state left in the FIFO and flags beforehand
        send_frame(8'h5A, BitCyc, 1'b1);
        send_frame(8'h00, BitCyc, 1'b0);
        rx_raw = 1'b1;
        idle(BitCyc);
        check("pre_rst_count", count, 1);
        check("pre_rst_ferr", frame_err, 1);
        fork
            send_frame(8'hFF, BitCyc, 1'b1);
            begin
                idle(5 * BitCyc);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("mid_rst_valid", valid, 0);
                check("mid_rst_count", count, 0);
                check("mid_rst_overrun", overrun, 0);
                check("mid_rst_ferr", frame_err, 0);
            end
        join
        idle(20);
        check("post_rst_no_byte", count, 0);
        send_frame(8'hC3, BitCyc, 1'b1);
        idle(20);
        check("post_rst_count", count, 1);
        check("post_rst_C3", rx_data, 8'hC3);
        pop_byte();
        send_frame(8'hC3, FastCyc, 1'b1);
        idle(20);
        check("fast_count", count, 1);
        check("fast_C3", rx_data, 8'hC3);
        check("fast_ferr", frame_err, 0);
        pop_byte();
        check("final_empty", valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
